// File: rtl/manchester_unescape_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the unescaper.
interface manchester_unescape_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/manchester_unescape.sv
// Receive-side unescaper: strips ESCAPE_SYMBOL prefixes, restores the literal
// byte that follows, flags protocol violations and counts escape pairs.
module manchester_unescape #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] ESCAPED_SYMBOL = 8'hD5,
  parameter logic [DATA_WIDTH-1:0] ESCAPE_SYMBOL  = 8'hE5,
  parameter int unsigned           CNT_WIDTH      = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  manchester_unescape_if.slave  s_axis,
  manchester_unescape_if.master m_axis,
  output logic                 err_bad_escape,
  output logic                 err_dangling,
  output logic [CNT_WIDTH-1:0] stat_escape_count
);

  typedef enum logic {
    ST_DATA,
    ST_ESC
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  err_bad_q, err_bad_d;
  logic                  err_dang_q, err_dang_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic s_ready;
  logic accept;

  assign s_ready = !out_valid_q || m_axis.tready;
  assign accept  = s_axis.tvalid && s_ready;

  // Next-state, output register load, error pulses and escape counting.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    err_bad_d   = 1'b0;
    err_dang_d  = 1'b0;
    count_d     = count_q;

    if (out_valid_q && m_axis.tready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        ST_DATA: begin
          if (s_axis.tdata == ESCAPE_SYMBOL) begin
            if (s_axis.tlast) begin
              err_dang_d = 1'b1;
            end else begin
              state_d = ST_ESC;
            end
          end else begin
            out_valid_d = 1'b1;
            out_data_d  = s_axis.tdata;
            out_last_d  = s_axis.tlast;
          end
        end
        ST_ESC: begin
          out_valid_d = 1'b1;
          out_data_d  = s_axis.tdata;
          out_last_d  = s_axis.tlast;
          state_d     = ST_DATA;
          if ((s_axis.tdata == ESCAPED_SYMBOL) || (s_axis.tdata == ESCAPE_SYMBOL)) begin
            count_d = count_q + CNT_WIDTH'(1);
          end else begin
            err_bad_d = 1'b1;
          end
        end
        default: state_d = ST_DATA;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_DATA;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_bad_q   <= 1'b0;
      err_dang_q  <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      err_bad_q   <= err_bad_d;
      err_dang_q  <= err_dang_d;
      count_q     <= count_d;
    end
  end

  assign s_axis.tready     = s_ready;
  assign m_axis.tdata      = out_data_q;
  assign m_axis.tlast      = out_last_q;
  assign m_axis.tvalid     = out_valid_q;
  assign err_bad_escape    = err_bad_q;
  assign err_dangling      = err_dang_q;
  assign stat_escape_count = count_q;

endmodule
